// File: rtl/sarm_mem_pkg.sv
// sarm_mem_pkg: shared types and constants for the SRAM memory controller
package sarm_mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
    localparam int ADDR_BASE_DEF = 1024;
    localparam int HW = 16;
endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: MEM-stage word access bus between pipeline (master) and SRAM controller (slave)
// wr_en/rd_en: held requests; address: byte address; write_data/read_data: 32-bit words;
// ready: 1 when no access is pending, 0 freezes the pipeline
interface sram_ctrl_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    modport master(output wr_en, rd_en, address, write_data, input read_data, ready);
    modport slave(input wr_en, rd_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits each 32-bit MEM-stage access into two timed halfword accesses on a 16-bit async SRAM
// clk/rst: clock and synchronous active-high reset; mem: word bus to the MEM stage;
// sram_addr: halfword address; sram_dq_out/sram_dq_oe/sram_dq_in: data pad; sram_we_n/sram_oe_n: strobes
module sram_ctrl
    import sarm_mem_pkg::*;
#(
    parameter int ACCESS_CYCLES = 3,
    parameter int ADDR_BASE     = ADDR_BASE_DEF,
    parameter int SRAM_AW       = 18
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         mem,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [HW-1:0]      sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [HW-1:0]      sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACCESS_CYCLES - 1);
    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               is_wr, last, busy, req;
    logic [SRAM_AW-2:0] idx;
    logic [31:0]        wdata, rdata;
    assign req  = mem.rd_en || mem.wr_en;
    assign busy = state == LO || state == HI;
    assign last = cnt == LAST;
    always_comb begin
        state_nx = state;
        cnt_nx   = (busy && !last) ? cnt + 1'b1 : '0;
        if (state == IDLE) state_nx = req ? LO : IDLE;
        else if (state == DONE) state_nx = IDLE;
        else if (last) state_nx = state == LO ? HI : DONE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            is_wr <= 1'b0;
            idx   <= '0;
            wdata <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE && req) begin
                is_wr <= mem.wr_en;
                // byte offset to word index; the cast drops address[1:0] and wraps out-of-range indices
                idx   <= (SRAM_AW-1)'((mem.address - 32'(ADDR_BASE)) >> 2);
                wdata <= mem.write_data;
            end
            // capture each half at the end of its phase, after a full access time
            if (busy && !is_wr && last) begin
                if (state == LO) rdata[15:0] <= sram_dq_in;
                else rdata[31:16] <= sram_dq_in;
            end
        end
    end
    assign mem.ready     = (state == IDLE && !req) || state == DONE;
    assign mem.read_data = rdata;
    assign sram_addr     = busy ? {idx, state == HI} : '0;
    assign sram_dq_oe    = busy && is_wr;
    assign sram_dq_out   = sram_dq_oe ? (state == HI ? wdata[31:16] : wdata[15:0]) : '0;
    // WE rises one cycle before the phase ends so address/data are held past the rising edge
    assign sram_we_n     = !(sram_dq_oe && !last);
    assign sram_oe_n     = !(busy && !is_wr);
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: randomized self-checking bench with a cycle-level behavioural model and an SRAM array
module tb_sram_ctrl;
    localparam int AC = 3;
    localparam int AW = 18;
    localparam int NH = 1 << AW;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    sram_ctrl_if mem();
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out, sram_dq_in;
    logic          sram_dq_oe, sram_we_n, sram_oe_n;
    logic [15:0]   sram  [0:NH-1];
    logic [15:0]   msram [0:NH-1];
    int nchk = 0;
    int nerr = 0;
    sram_ctrl #(.ACCESS_CYCLES(AC), .ADDR_BASE(1024), .SRAM_AW(AW)) dut (
        .clk(clk), .rst(rst), .mem(mem),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );
    assign sram_dq_in = sram_oe_n ? 16'hbad0 : sram[sram_addr];
    initial begin
        for (int i = 0; i < NH; i++) sram[i] = '0;
        forever begin
            @(negedge clk);
            if (!sram_we_n && sram_dq_oe) sram[sram_addr] <= sram_dq_out;
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask
    initial begin
        int k = -1;
        bit armed = 0;
        bit m_wr = 0;
        int unsigned m_idx = 0;
        int unsigned ha;
        int ph, pos;
        logic [31:0] m_wd = '0, m_rd = '0, ofs;
        logic e_ready, e_we_n, e_oe_n, e_oe;
        logic [AW-1:0] e_addr;
        logic [15:0] e_dq;
        for (int i = 0; i < NH; i++) msram[i] = '0;
        forever begin
            @(negedge clk);
            if (armed) begin
                e_ready = 1'b0; e_we_n = 1'b1; e_oe_n = 1'b1; e_oe = 1'b0; e_addr = '0; e_dq = '0;
                if (k < 0) e_ready = !(mem.rd_en || mem.wr_en);
                else if (k <= 2 * AC) begin
                    ph = (k - 1) / AC;
                    pos = (k - 1) % AC;
                    ha = 2 * m_idx + ph;
                    e_addr = ha[AW-1:0];
                    if (m_wr) begin
                        e_oe = 1'b1;
                        e_dq = ph != 0 ? m_wd[31:16] : m_wd[15:0];
                        e_we_n = pos == AC - 1;
                        if (pos == AC - 2) msram[ha] = e_dq;
                    end else e_oe_n = 1'b0;
                end else begin
                    e_ready = 1'b1;
                    if (m_wr) begin
                        chk("sram_lo", sram[2*m_idx], msram[2*m_idx]);
                        chk("sram_hi", sram[2*m_idx+1], msram[2*m_idx+1]);
                    end else m_rd = {msram[2*m_idx+1], msram[2*m_idx]};
                end
                chk("ready", mem.ready, e_ready);
                chk("we_n", sram_we_n, e_we_n);
                chk("oe_n", sram_oe_n, e_oe_n);
                chk("dq_oe", sram_dq_oe, e_oe);
                if (k >= 1 && k <= 2 * AC) chk("sram_addr", sram_addr, e_addr);
                if (e_oe) chk("dq_out", sram_dq_out, e_dq);
                if (k < 0 || k > 2 * AC) chk("read_data", mem.read_data, m_rd);
            end
            if (rst) begin
                k = -1;
                m_rd = '0;
                armed = 1;
            end else if (armed) begin
                if (k < 0 && (mem.rd_en || mem.wr_en)) begin
                    m_wr = mem.wr_en;
                    ofs = mem.address - 32'd1024;
                    m_idx = (ofs / 4) % (NH / 2);
                    m_wd = mem.write_data;
                    k = 1;
                end else if (k >= 0) k = k > 2 * AC ? -1 : k + 1;
            end
        end
    end
    task automatic op(input bit b2b, input bit w, input bit r, input logic [31:0] a,
                      input logic [31:0] d, output int lat, output logic [7:0] wem);
        if (b2b) #1;
        else begin
            @(posedge clk);
            #1;
        end
        mem.wr_en = w; mem.rd_en = r; mem.address = a; mem.write_data = d;
        lat = 0;
        wem = '0;
        do begin
            @(negedge clk);
            if (lat < 8) wem[lat] = !sram_we_n;
            lat++;
        end while (!mem.ready && lat < 100);
        if (!mem.ready) begin
            nchk++;
            nerr++;
            $display("FAIL op_timeout: ready never rose for address %h", a);
        end
        #1 mem.wr_en = 1'b0; mem.rd_en = 1'b0;
    endtask
    initial begin
        int lat, n, kind;
        logic [7:0] wem;
        logic [31:0] a;
        bit b2b;
        mem.wr_en = 1'b0; mem.rd_en = 1'b0; mem.address = '0; mem.write_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", mem.ready, 1);
        chk("rst_we_n", sram_we_n, 1);
        chk("rst_oe_n", sram_oe_n, 1);
        chk("rst_dq_oe", sram_dq_oe, 0);
        chk("rst_read_data", mem.read_data, 0);
        op(0, 1, 0, 32'd1024, 32'hdeadbeef, lat, wem);
        chk("wr_lat", lat, 8);
        chk("wr_we_mask", wem, 8'h36);
        chk("wr_sram0", sram[0], 16'hbeef);
        chk("wr_sram1", sram[1], 16'hdead);
        op(0, 0, 1, 32'd1024, 32'h0, lat, wem);
        chk("rd_lat", lat, 8);
        chk("rd_data", mem.read_data, 32'hdeadbeef);
        op(0, 1, 0, 32'd1028, 32'h12345678, lat, wem);
        chk("rd_kept_after_wr", mem.read_data, 32'hdeadbeef);
        op(1, 0, 1, 32'd1028, 32'h0, lat, wem);
        chk("b2b_lat", lat, 8);
        chk("b2b_sram2", sram[2], 16'h5678);
        chk("b2b_sram3", sram[3], 16'h1234);
        chk("b2b_rd", mem.read_data, 32'h12345678);
        op(0, 1, 1, 32'd1032, 32'h0000a5a5, lat, wem);
        chk("both_sram4", sram[4], 16'ha5a5);
        chk("both_sram5", sram[5], 16'h0000);
        chk("both_rd_kept", mem.read_data, 32'h12345678);
        op(0, 1, 0, 32'd1024, 32'h0, lat, wem);
        op(0, 0, 1, 32'd1024, 32'h0, lat, wem);
        chk("zero_rd", mem.read_data, 32'h0);
        @(posedge clk);
        #1 mem.rd_en = 1'b1; mem.address = 32'd1028;
        repeat (2) @(posedge clk);
        #1 mem.rd_en = 1'b0; mem.address = 32'd1032;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem.ready && n < 100);
        chk("drop_lat", n, 6);
        chk("drop_rd", mem.read_data, 32'h12345678);
        @(posedge clk);
        #1 mem.wr_en = 1'b1; mem.address = 32'd1040; mem.write_data = 32'h11112222;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1; mem.wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", mem.ready, 1);
        chk("mid_rst_we_n", sram_we_n, 1);
        chk("mid_rst_dq_oe", sram_dq_oe, 0);
        chk("mid_rst_sram9", sram[9], 16'h0000);
        chk("mid_rst_sram8", sram[8], 16'h2222);
        op(0, 1, 0, 32'd1020, 32'h0badcafe, lat, wem);
        chk("below_base_lo", sram[NH-2], 16'hcafe);
        chk("below_base_hi", sram[NH-1], 16'h0bad);
        op(0, 1, 0, 32'd1024 + (32'd1 << 19), 32'hcafef00d, lat, wem);
        chk("wrap_sram0", sram[0], 16'hf00d);
        op(0, 0, 1, 32'd1027, 32'h0, lat, wem);
        chk("wrap_rd", mem.read_data, 32'hcafef00d);
        b2b = 0;
        for (int i = 0; i < 80; i++) begin
            kind = $urandom_range(0, 2);
            a = $urandom_range(0, 7) == 0 ? $urandom : 32'd1024 + 4 * $urandom_range(0, 15) + $urandom_range(0, 3);
            op(b2b, kind != 1, kind != 0, a, $urandom, lat, wem);
            chk("rand_lat", lat, 8);
            b2b = $urandom_range(0, 2) == 0;
            if (!b2b) repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Memory-side controller downstream of the MEM stage. It replaces the single-cycle data memory with an external 16-bit asynchronous SRAM.
- Each 32-bit word access from the MEM stage becomes two timed halfword accesses.
- Drives `ready`. The top level freezes every pipeline stage and pipeline register while `ready` is 0.

Parameters:
- ACCESS_CYCLES, 3: clock cycles per halfword access phase (min 2).
- ADDR_BASE, 1024: byte address that maps to SRAM word 0.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- wr_en  in  1  word write request from MEM stage (held until ready)
- rd_en  in  1  word read request from MEM stage (held until ready)
- address  in  32  byte address (ALU result)
- write_data  in  32  store value
- read_data  out  32  loaded word
- ready  out  1  1 = no access pending; 0 = pipeline must freeze
- sram_addr  out  SRAM_AW  SRAM halfword address
- sram_dq_out  out  16  write data to pad
- sram_dq_oe  out  1  pad output enable
- sram_dq_in  in  16  read data from pad
- sram_we_n  out  1  active-low write enable
- sram_oe_n  out  1  active-low output enable

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, read_data=0, sram_addr=0, sram_dq_out=0.
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=1.
- States: IDLE, LO, HI, DONE.
- ready (combinational) = (IDLE & ~rd_en & ~wr_en) | DONE.
- IDLE:
  - On rd_en|wr_en, latch the request and go to LO; the phase counter loads 0.
  - Latched values: op (write wins if both asserted), word_idx = (address-ADDR_BASE)>>2, write_data.
  - address[1:0] are ignored.
- LO:
  - sram_addr = {word_idx[SRAM_AW-2:0],0}.
  - Counter increments each cycle. At count ACCESS_CYCLES-1, go to HI and reset the counter.
- HI:
  - sram_addr = low-phase address + 1.
  - Same count; at ACCESS_CYCLES-1, go to DONE.
- Writes:
  - sram_dq_oe=1 throughout LO/HI.
  - sram_dq_out = write_data[15:0] in LO, [31:16] in HI.
  - sram_we_n=0 on all cycles of a phase except its last, so address and data are held one cycle past WE rising.
  - sram_oe_n=1.
- Reads:
  - sram_oe_n=0 in LO/HI, sram_dq_oe=0, sram_we_n=1.
  - On the last cycle of LO, register sram_dq_in into read_data[15:0].
  - On the last cycle of HI, register it into read_data[31:16].
- DONE:
  - Lasts one cycle; ready=1 so the pipeline advances.
  - Unconditionally returns to IDLE, even if a request is asserted. The request then present is treated as new.
- Latency: request first seen in IDLE at cycle 0 gives DONE (ready=1) at cycle 2·ACCESS_CYCLES+1. With the default that is cycle 7.
- read_data is valid in DONE. It holds until the next read overwrites it; writes never change it.
- Requests dropped mid-access: the access completes using the latched values.
- Changes to address/data after acceptance are ignored.
- Reset mid-write: returns to IDLE at the next edge with all strobes deasserted. A partial SRAM write (low half only) is permitted.
- Word index overflow beyond SRAM_AW-1 bits is truncated (wrap-around).
- Addresses below ADDR_BASE wrap modulo 2^(SRAM_AW-1) words.

Decomposition:
- Shared package sarm_mem_pkg holds:
  - state enum (IDLE/LO/HI/DONE)
  - ADDR_BASE default
  - halfword width constant 16
- No sub-module required.
- The phase counter is inline; width is clog2(ACCESS_CYCLES).

Test Plan:
1. Idle, no request, after reset → ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
2. wr_en, address=1024, write_data=0xDEADBEEF, held → SRAM model addr 0 = 0xBEEF, addr 1 = 0xDEAD; ready=0 at cycles 0–6, ready=1 at cycle 7; sram_we_n low at cycles 1–2 and 4–5 only.
3. rd_en, address=1024 after test 2 → read_data=0xDEADBEEF in DONE (cycle 7); value retained through a later write.
4. Back-to-back: write 0x12345678 to 1028, then read from 1028 presented in the DONE cycle → second access starts the cycle after DONE; SRAM addrs 2/3 = 0x5678/0x1234; read returns 0x12345678 at cycle 15.
5. rst=1 at cycle 2 of a write → next edge: IDLE, sram_we_n=1, sram_dq_oe=0; SRAM addr 1 unchanged; ready=1 if the request is deasserted.
6. rd_en=wr_en=1, address=1032, write_data=0xA5A5 → write performed (addrs 4/5 = 0xA5A5/0x0000); read_data unchanged.
